// File: rtl/sd_dac_multi.sv
// Multi-channel sigma-delta DAC: one-deep frame buffer, clock-enable divider and
// per-channel 1st/2nd-order modulators with mute and order-change integrator clear.
module sd_dac_multi #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned CE_DIV   = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] DACin,
  input  logic                      DACin_valid,
  output logic                      DACin_ready,
  input  logic                      Mute,
  input  logic                      Order2,
  output logic                      Load,
  output logic [CHANNELS-1:0]       DACout
);

  localparam int unsigned FW = CHANNELS * WIDTH;
  localparam int unsigned CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int unsigned IW = WIDTH + 4;
  localparam int unsigned SW = IW + 2;

  localparam logic [CW-1:0]        CE_LAST = CW'(CE_DIV - 1);
  localparam logic [WIDTH-1:0]     MID     = WIDTH'(2 ** (WIDTH - 1));
  localparam logic signed [SW-1:0] HALF    = SW'(2 ** (WIDTH - 1));
  localparam logic signed [SW-1:0] IMAX    = SW'(2 ** (IW - 1) - 1);
  localparam logic signed [SW-1:0] IMIN    = ~IMAX;

  // Clamp a wide integrator sum into the signed integrator range.
  function automatic logic signed [IW-1:0] sat_f(input logic signed [SW-1:0] v);
    if (v > IMAX) begin
      return IW'(IMAX);
    end else if (v < IMIN) begin
      return IW'(IMIN);
    end
    return IW'(v);
  endfunction

  logic [CW-1:0] ce_cnt_q, ce_cnt_d;
  logic          pend_full_q, pend_full_d;
  logic [FW-1:0] pend_q, pend_d;
  logic [FW-1:0] active_q, active_d;
  logic          ready_q, ready_d;
  logic          load_q, load_d;
  logic          ord_q, ord_d;
  logic          ce_c;
  logic          accept_c;
  logic          xfer_c;
  logic          clr_c;
  logic [FW-1:0] mod_in_c;

  // Shared control: CE divider, frame buffer handshake, order tracking.
  always_comb begin
    ce_cnt_d    = ce_cnt_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    active_d    = active_q;
    ready_d     = ready_q;
    load_d      = 1'b0;
    ord_d       = ord_q;

    ce_c     = (ce_cnt_q == CE_LAST);
    accept_c = DACin_valid & ready_q;
    xfer_c   = ce_c & pend_full_q;
    clr_c    = ce_c & (Order2 != ord_q);

    ce_cnt_d = ce_c ? '0 : ce_cnt_q + CW'(1);
    if (accept_c) begin
      pend_d = DACin;
    end
    if (xfer_c) begin
      pend_full_d = 1'b0;
      active_d    = pend_q;
    end else if (accept_c) begin
      pend_full_d = 1'b1;
    end
    ready_d = ~pend_full_d;
    load_d  = xfer_c;
    if (ce_c) begin
      ord_d = Order2;
    end

    // A frame transferred at this CE already drives this CE's update.
    mod_in_c = Mute ? {CHANNELS{MID}} : active_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ce_cnt_q    <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      active_q    <= {CHANNELS{MID}};
      ready_q     <= 1'b1;
      load_q      <= 1'b0;
      ord_q       <= 1'b0;
    end else begin
      ce_cnt_q    <= ce_cnt_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      active_q    <= active_d;
      ready_q     <= ready_d;
      load_q      <= load_d;
      ord_q       <= ord_d;
    end
  end

  assign DACin_ready = ready_q;
  assign Load        = load_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0]     x_c;
    logic [WIDTH-1:0]     acc_q, acc_d, acc_b;
    logic [WIDTH:0]       sum1_c;
    logic signed [IW-1:0] i1_q, i1_d, i1_b, i1_s;
    logic signed [IW-1:0] i2_q, i2_d, i2_b;
    logic signed [SW-1:0] u_c, fb_c, s1_c, s2_c;
    logic                 y_q, y_d;

    // Per-channel modulator; integrators start from zero on an order change.
    always_comb begin
      acc_d = acc_q;
      i1_d  = i1_q;
      i2_d  = i2_q;
      y_d   = y_q;

      x_c   = mod_in_c[k*WIDTH +: WIDTH];
      acc_b = clr_c ? '0 : acc_q;
      i1_b  = clr_c ? '0 : i1_q;
      i2_b  = clr_c ? '0 : i2_q;

      sum1_c = {1'b0, acc_b} + {1'b0, x_c};
      u_c    = $signed(SW'({1'b0, x_c})) - HALF;
      fb_c   = y_q ? HALF : -HALF;
      s1_c   = SW'(i1_b) + u_c - fb_c;
      i1_s   = sat_f(s1_c);
      s2_c   = SW'(i2_b) + SW'(i1_s) - fb_c;

      if (ce_c) begin
        acc_d = acc_b;
        i1_d  = i1_b;
        i2_d  = i2_b;
        if (Order2) begin
          i1_d = i1_s;
          i2_d = sat_f(s2_c);
          y_d  = ~i2_d[IW-1];
        end else begin
          acc_d = sum1_c[WIDTH-1:0];
          y_d   = sum1_c[WIDTH];
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        acc_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
        y_q   <= 1'b0;
      end else begin
        acc_q <= acc_d;
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        y_q   <= y_d;
      end
    end

    assign DACout[k] = y_q;
  end

endmodule

// File: tb/tb_sd_dac_multi.sv
// Bench for sd_dac_multi: accepted frames feed a scoreboard queue, a monitor runs
// an arithmetic reference model every cycle, directed density tests plus random traffic.
module tb_sd_dac_multi;

  localparam int unsigned CH     = 2;
  localparam int unsigned W      = 9;
  localparam int unsigned CE_DIV = 3;
  localparam int          MIDV   = 256;
  localparam int          IMAXV  = 4095;
  localparam int          IMINV  = -4096;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [CH*W-1:0] DACin;
  logic            valid;
  logic            ready;
  logic            Mute;
  logic            Order2;
  logic            Load;
  logic [CH-1:0]   DACout;

  sd_dac_multi #(.CHANNELS(CH), .WIDTH(W), .CE_DIV(CE_DIV)) dut (
    .Clk(Clk), .Reset(Reset), .DACin(DACin), .DACin_valid(valid),
    .DACin_ready(ready), .Mute(Mute), .Order2(Order2), .Load(Load), .DACout(DACout)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  logic [CH*W-1:0] frame_q[$];
  int              ce_total;
  int              ones[CH];
  int              ce_bits[$];
  int              load_cyc[$];
  int              cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > IMAXV) return IMAXV;
    if (v < IMINV) return IMINV;
    return v;
  endfunction

  // Reference model state
  int unsigned     m_cnt;
  bit              m_ce, m_acc, m_pend, m_rdy, m_ld, m_ord;
  int              m_act[CH];
  longint          m_tot[CH];
  int              m_i1[CH], m_i2[CH];
  bit              m_y[CH];
  logic [CH*W-1:0] m_f;
  int              m_x, m_u, m_fb;
  longint          m_before;

  // Monitor: advance the model on each edge, compare registered outputs just after.
  always begin
    @(posedge Clk);
    m_ce = 1'b0;
    if (Reset) begin
      m_cnt = 0; m_pend = 1'b0; m_rdy = 1'b1; m_ld = 1'b0; m_ord = 1'b0;
      frame_q.delete();
      for (int c = 0; c < CH; c++) begin
        m_act[c] = MIDV; m_tot[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 1'b0;
      end
    end else begin
      m_ce  = (m_cnt == CE_DIV - 1);
      m_cnt = m_ce ? 0 : m_cnt + 1;
      m_acc = valid && m_rdy;
      m_ld  = m_ce && m_pend;
      if (m_ld) begin
        chk("sb_frame_avail", frame_q.size(), 1);
        if (frame_q.size() > 0) begin
          m_f = frame_q.pop_front();
          for (int c = 0; c < CH; c++) m_act[c] = int'(m_f[c*W +: W]);
        end
        m_pend = 1'b0;
      end
      if (m_acc) m_pend = 1'b1;
      m_rdy = !m_pend;
      if (m_ce) begin
        if (Order2 != m_ord) begin
          for (int c = 0; c < CH; c++) begin m_tot[c] = 0; m_i1[c] = 0; m_i2[c] = 0; end
        end
        m_ord = Order2;
        for (int c = 0; c < CH; c++) begin
          m_x = Mute ? MIDV : m_act[c];
          if (!Order2) begin
            // Output is 1 whenever the running sum crosses a multiple of 2^W.
            m_before = m_tot[c] / 512;
            m_tot[c] += m_x;
            m_y[c] = (m_tot[c] / 512) != m_before;
          end else begin
            m_u  = m_x - MIDV;
            m_fb = m_y[c] ? MIDV : -MIDV;
            m_i1[c] = clamp(m_i1[c] + m_u - m_fb);
            m_i2[c] = clamp(m_i2[c] + m_i1[c] - m_fb);
            m_y[c] = (m_i2[c] >= 0);
          end
        end
      end
    end
    #1;
    cyc++;
    for (int c = 0; c < CH; c++) chk($sformatf("dacout%0d", c), DACout[c], m_y[c]);
    chk("load", Load, m_ld);
    chk("ready", ready, m_rdy);
    if (m_ce) begin
      ce_total++;
      for (int c = 0; c < CH; c++) ones[c] += int'(DACout[c]);
      ce_bits.push_back(int'(DACout[0]));
    end
    if (Load) load_cyc.push_back(cyc);
  end

  // Offer a frame (called at a negedge); returns at the negedge after acceptance.
  task automatic send_frame(input logic [CH*W-1:0] f);
    int n = 0;
    DACin = f;
    valid = 1'b1;
    while (!ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!ready) begin
      chk("accept_timeout", n, 0);
    end else begin
      frame_q.push_back(f);
      @(negedge Clk);
    end
    valid = 1'b0;
  endtask

  // Clear statistics and wait for exactly n clock enables.
  task automatic wait_ces(input int n);
    int guard = 0;
    ce_total = 0;
    for (int c = 0; c < CH; c++) ones[c] = 0;
    while (ce_total < n && guard < n * int'(CE_DIV) + 20) begin
      @(negedge Clk);
      guard++;
    end
    if (ce_total < n) chk("ce_timeout", ce_total, n);
  endtask

  function automatic int bit_at(input int i);
    return (ce_bits.size() > i) ? ce_bits[i] : -1;
  endfunction

  int bad;
  int dly;

  initial begin
    Reset = 1'b1; valid = 1'b0; Mute = 1'b0; Order2 = 1'b0; DACin = '0;
    repeat (3) @(negedge Clk);
    chk("reset_dacout", DACout, 0);
    chk("reset_ready", ready, 1);
    chk("reset_load", Load, 0);
    Reset = 1'b0;

    // Active starts at midscale: 0,1,0,1 from zero accumulators
    wait_ces(4);
    chk("mid_default_ones", ones[0], 2);

    // 1st order, ch0 midscale alternates, ch1 = 300
    send_frame({9'd300, 9'd256});
    wait_ces(2);
    ce_bits.delete();
    wait_ces(512);
    bad = 0;
    for (int i = 1; i < ce_bits.size(); i++) if (ce_bits[i] == ce_bits[i-1]) bad++;
    chk("t1_alternate", bad, 0);
    chk("t1_ones_ch0", ones[0], 256);
    chk("t1_ones_ch1", ones[1], 300);

    // Extremes
    send_frame({9'd511, 9'd0});
    wait_ces(2);
    wait_ces(512);
    chk("t2_ones_ch0", ones[0], 0);
    chk("t2_ones_ch1", ones[1], 511);

    // Back-to-back frames: loads one CE period apart
    load_cyc.delete();
    send_frame({9'd10, 9'd20});
    send_frame({9'd30, 9'd40});
    wait_ces(2);
    chk("t3_load_count", load_cyc.size(), 2);
    chk("t3_load_spacing", (load_cyc.size() >= 2) ? load_cyc[1] - load_cyc[0] : -1, CE_DIV);

    // 2nd order density
    Order2 = 1'b1;
    send_frame({9'd128, 9'd384});
    wait_ces(16);
    wait_ces(4096);
    chk_rng("t4_ones_ch0", ones[0], 3070, 3074);
    chk_rng("t4_ones_ch1", ones[1], 1022, 1026);

    // 2nd order near full scale must not wrap
    send_frame({9'd1, 9'd511});
    wait_ces(16);
    wait_ces(10000);
    chk_rng("t5_ones_ch0", ones[0], 9970, 10000);

    // Mute forces midscale, active resumes afterwards
    Order2 = 1'b0;
    send_frame({9'd200, 9'd100});
    wait_ces(4);
    Mute = 1'b1;
    wait_ces(1024);
    chk_rng("t6_mute_ones", ones[0], 510, 514);
    Mute = 1'b0;
    wait_ces(512);
    chk("t6_unmute_ch0", ones[0], 100);
    chk("t6_unmute_ch1", ones[1], 200);

    // Order toggles restart from zeroed integrators
    Order2 = 1'b1;
    send_frame({9'd0, 9'd256});
    wait_ces(37);
    Order2 = 1'b0;
    ce_bits.delete();
    wait_ces(2);
    chk("t7_o1_bit0", bit_at(0), 0);
    chk("t7_o1_bit1", bit_at(1), 1);
    Order2 = 1'b1;
    ce_bits.delete();
    wait_ces(3);
    chk("t7_o2_bit0", bit_at(0), 0);
    chk("t7_o2_bit1", bit_at(1), 0);
    chk("t7_o2_bit2", bit_at(2), 1);

    // Reset with a frame pending: it must be lost
    Order2 = 1'b0;
    send_frame({9'd50, 9'd50});
    Reset = 1'b1;
    @(negedge Clk);
    chk("t8_dacout", DACout, 0);
    chk("t8_ready", ready, 1);
    chk("t8_load", Load, 0);
    Reset = 1'b0;
    load_cyc.delete();
    wait_ces(4);
    chk("t8_mid_ones", ones[0], 2);
    repeat (20) @(negedge Clk);
    chk("t8_no_load", load_cyc.size(), 0);

    // Random traffic checked cycle by cycle by the monitor
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 99)) inside
        [0:34]:  send_frame(CH*W'($urandom));
        [35:39]: begin Mute = ~Mute; @(negedge Clk); end
        [40:42]: begin Order2 = ~Order2; @(negedge Clk); end
        [43:43]: begin Reset = 1'b1; @(negedge Clk); Reset = 1'b0; end
        default: begin
          dly = $urandom_range(1, 4);
          repeat (dly) @(negedge Clk);
        end
      endcase
    end
    repeat (10) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
